// File: rtl/design_variables.sv
// Shared constants and types for the alignment datapath.
package design_variables;
  localparam int SEQ_LENGTH   = 32;
  localparam int LETTER_WIDTH = 2;
  localparam int GAP_BIT      = LETTER_WIDTH;
  localparam int ALIGN_DEPTH  = 2 * SEQ_LENGTH;
  localparam int ALIGN_LEN_W  = $clog2(ALIGN_DEPTH + 1);

  typedef struct packed {
    logic [LETTER_WIDTH:0] query_sym;
    logic [LETTER_WIDTH:0] database_sym;
  } align_pair_t;
endpackage

// File: rtl/align_lifo.sv
// Register stack holding symbol pairs; top_data reads stack[sp-1] combinationally.
module align_lifo #(
  parameter int DEPTH = 64,
  parameter int W     = 6,
  parameter int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     top_data,
  output logic [LEN_W-1:0] sp,
  output logic             full,
  output logic             empty
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     stack [DEPTH];
  logic [LEN_W-1:0] sp_q;
  logic             do_push, do_pop;

  assign full    = (sp_q == LEN_W'(DEPTH));
  assign empty   = (sp_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign sp      = sp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       sp_q <= '0;
    else if (do_push) sp_q <= sp_q + LEN_W'(1);
    else if (do_pop)  sp_q <= sp_q - LEN_W'(1);
  end

  // Storage is intentionally unreset; sp alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push) stack[IDX_W'(sp_q)] <= push_data;
  end

  assign top_data = empty ? '0 : stack[IDX_W'(sp_q - LEN_W'(1))];
endmodule

// File: rtl/alignment_writer.sv
// Collects traceback pairs (end-to-start) on a stack and replays them start-first.
module alignment_writer
  import design_variables::*;
#(
  parameter int ALIGN_DEPTH = 2 * SEQ_LENGTH,
  parameter int SYM_W       = LETTER_WIDTH + 1,
  parameter int LEN_W       = $clog2(ALIGN_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tb_valid,
  input  logic [SYM_W-1:0] tb_query_sym,
  input  logic [SYM_W-1:0] tb_database_sym,
  input  logic             tb_last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [SYM_W-1:0] out_query_sym,
  output logic [SYM_W-1:0] out_database_sym,
  output logic             out_last,
  output logic [LEN_W-1:0] align_len,
  output logic             busy,
  output logic             error
);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t             state_q, state_d;
  logic               err_q, err_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               push, pop;
  logic [LEN_W-1:0]   sp;
  logic               full, empty;
  logic [2*SYM_W-1:0] top_pair;

  align_lifo #(.DEPTH(ALIGN_DEPTH), .W(2*SYM_W), .LEN_W(LEN_W)) u_lifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({tb_query_sym, tb_database_sym}),
    .pop       (pop),
    .top_data  (top_pair),
    .sp        (sp),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      len_q   <= len_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    len_d   = len_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (tb_valid) begin
          push  = 1'b1;
          err_d = 1'b0;
          if (tb_last) begin
            state_d = DRAIN;
            len_d   = LEN_W'(1);
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (tb_valid) begin
          // A push at full is dropped but tb_last still ends the collection.
          if (full) err_d = 1'b1;
          else      push  = 1'b1;
          if (tb_last) begin
            state_d = DRAIN;
            len_d   = full ? sp : sp + LEN_W'(1);
          end
        end
      end
      DRAIN: begin
        if (tb_valid) err_d = 1'b1;
        if (out_ready && !empty) begin
          pop = 1'b1;
          if (sp == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid        = (state_q == DRAIN);
  assign out_last         = out_valid && (sp == LEN_W'(1));
  assign out_query_sym    = out_valid ? top_pair[2*SYM_W-1:SYM_W] : '0;
  assign out_database_sym = out_valid ? top_pair[SYM_W-1:0] : '0;
  assign align_len        = len_q;
  assign busy             = (state_q != IDLE);
  assign error            = err_q;
endmodule

// File: tb/tb_alignment_writer.sv
// Directed bench: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_alignment_writer;
  import design_variables::*;

  logic       clk, rst_n;
  logic       tb_valid, tb_last, out_ready;
  logic [2:0] tb_query_sym, tb_database_sym;
  logic       out_valid, out_last, busy, error;
  logic [2:0] out_query_sym, out_database_sym;
  logic [6:0] align_len;

  int tests = 0;
  int fails = 0;

  alignment_writer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tb_valid         (tb_valid),
    .tb_query_sym     (tb_query_sym),
    .tb_database_sym  (tb_database_sym),
    .tb_last          (tb_last),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_query_sym    (out_query_sym),
    .out_database_sym (out_database_sym),
    .out_last         (out_last),
    .align_len        (align_len),
    .busy             (busy),
    .error            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs applied this cycle and the outputs expected in the same cycle.
  typedef struct {
    logic        v;
    align_pair_t p;
    logic        l;
    logic        rdy;
    logic [16:0] want;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [16:0] expv(logic ov, logic [2:0] q, logic [2:0] d, logic ol,
                                       logic [6:0] len, logic b, logic e);
    return {ov, q, d, ol, len, b, e};
  endfunction

  function automatic vec_t mk(logic v, logic [2:0] q, logic [2:0] d, logic l, logic rdy,
                              logic ov, logic [2:0] oq, logic [2:0] od, logic ol,
                              logic [6:0] len, logic b, logic e);
    vec_t r;
    r.v = v; r.p.query_sym = q; r.p.database_sym = d; r.l = l; r.rdy = rdy;
    r.want = expv(ov, oq, od, ol, len, b, e);
    return r;
  endfunction

  function automatic logic [16:0] outs();
    return {out_valid, out_query_sym, out_database_sym, out_last, align_len, busy, error};
  endfunction

  task automatic drive(logic v, logic [2:0] q, logic [2:0] d, logic l, logic rdy);
    tb_valid = v; tb_query_sym = q; tb_database_sym = d; tb_last = l; out_ready = rdy;
  endtask

  task automatic check(string name, logic [16:0] act, logic [16:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h (v q d last len busy err) expected %h", name, act, want);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #1 check("reset_state", outs(), expv(0, 0, 0, 0, 0, 0, 0));
    #10 rst_n = 1'b1;

    // Gap symbols
    vecs.push_back(mk(1, 3'b100, 3'b011, 0, 1,  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b010, 3'b100, 1, 1,  0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,            1, 3'b010, 3'b100, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,            1, 3'b100, 3'b011, 1, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,            0, 0, 0, 0, 2, 0, 0));
    // Collect stall, then backpressure 1,0,0,1 in drain
    vecs.push_back(mk(1, 3'b001, 3'b010, 0, 0,  0, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0, 0, 2, 1, 0));
    vecs.push_back(mk(1, 3'b011, 3'b000, 0, 0,  0, 0, 0, 0, 2, 1, 0));
    vecs.push_back(mk(1, 3'b100, 3'b101, 1, 0,  0, 0, 0, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,            1, 3'b100, 3'b101, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 3'b011, 3'b000, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 3'b011, 3'b000, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,            1, 3'b011, 3'b000, 0, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,            1, 3'b001, 3'b010, 1, 3, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,            0, 0, 0, 0, 3, 0, 0));
    // Protocol error during drain; next IDLE push (with last) clears it
    vecs.push_back(mk(1, 3'b001, 3'b001, 0, 1,  0, 0, 0, 0, 3, 0, 0));
    vecs.push_back(mk(1, 3'b010, 3'b010, 1, 1,  0, 0, 0, 0, 3, 1, 0));
    vecs.push_back(mk(1, 3'b111, 3'b111, 0, 1,  1, 3'b010, 3'b010, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,            1, 3'b001, 3'b001, 1, 2, 1, 1));
    vecs.push_back(mk(1, 3'b011, 3'b011, 1, 1,  0, 0, 0, 0, 2, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1,            1, 3'b011, 3'b011, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,            0, 0, 0, 0, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].p.query_sym, vecs[i].p.database_sym, vecs[i].l, vecs[i].rdy);
      #1 check($sformatf("vec%0d", i), outs(), vecs[i].want);
    end

    // Eight pairs P0..P7 (q=k, d=7-k), replayed P7..P0
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(1, 3'(k), 3'(7 - k), k == 7, 1);
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 1);
      #1 check($sformatf("eight_drain%0d", j), outs(),
               expv(1, 3'(7 - j), 3'(j), j == 7, 8, 1, 0));
    end
    @(negedge clk);
    #1 check("eight_idle", outs(), expv(0, 0, 0, 0, 8, 0, 0));

    // Full: 65 pushes, the 65th (q=0,d=0) must be dropped
    for (int k = 0; k < 65; k++) begin
      @(negedge clk);
      drive(1, 3'(k), 3'(k >> 3), k == 64, 1);
    end
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 1);
      #1 check($sformatf("full_drain%0d", j), outs(),
               expv(1, 3'(63 - j), 3'((63 - j) >> 3), j == 63, 64, 1, 1));
    end
    @(negedge clk);
    #1 check("full_idle", outs(), expv(0, 0, 0, 0, 64, 0, 1));

    // Reset mid-collect
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 3'(k + 1), 3'(k + 4), 0, 1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    rst_n = 1'b0;
    #1 check("rst_async", outs(), expv(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_release", outs(), expv(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(1, 3'b101, 3'b110, 1, 1);
    #1 check("rst_push", outs(), expv(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    #1 check("rst_single", outs(), expv(1, 3'b101, 3'b110, 1, 1, 1, 0));
    @(negedge clk);
    #1 check("rst_idle", outs(), expv(0, 0, 0, 0, 1, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alignment_writer.md
# alignment_writer

Downstream of `traceback`, `alignment_writer` captures the aligned symbol pairs that `traceback` emits one per cycle. These pairs arrive from the end of the alignment back to its start. The block stores them in a register stack, then replays them in forward order (alignment start first) over a valid/ready stream to the result interface. It also reports the alignment length and flags protocol errors.

## Interface
- `ALIGN_DEPTH`, default `2*SEQ_LENGTH` (64): stack capacity in symbol pairs.
- `SYM_W`, default `LETTER_WIDTH+1` (3): symbol width. Bit `SYM_W-1` is the gap flag; the low `LETTER_WIDTH` bits hold the letter.
- `LEN_W`, default `$clog2(ALIGN_DEPTH+1)` (7): length/count width.
- `clk`  in  1  Single clock, rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `tb_valid`  in  1  Symbol pair from `traceback` is valid this cycle.
- `tb_query_sym`  in  `SYM_W`  Query symbol, from `traceback` `query_seq_out`.
- `tb_database_sym`  in  `SYM_W`  Database symbol, from `traceback` `database_seq_out`.
- `tb_last`  in  1  Pair is the final one (`traceback` `finished`). Qualified by `tb_valid`.
- `out_ready`  in  1  Consumer accepts a pair.
- `out_valid`  out  1  Output pair valid.
- `out_query_sym`  out  `SYM_W`  Forward-order query symbol.
- `out_database_sym`  out  `SYM_W`  Forward-order database symbol.
- `out_last`  out  1  Current output pair is the final one.
- `align_len`  out  `LEN_W`  Number of pairs in the last completed collection.
- `busy`  out  1  State is not IDLE.
- `error`  out  1  Sticky error: push at full, or `tb_valid` seen during DRAIN.

## Operation
- **FSM states:** IDLE, COLLECT, DRAIN. State is encoded in an enum.
- **IDLE:**
  - `tb_valid` pushes the pair, clears `error`, sets `sp` to 1.
  - Next state is COLLECT, or DRAIN if `tb_last` is also set.
- **COLLECT:**
  - Each `tb_valid` pushes `{query, database}` at `stack[sp]` and increments `sp`.
  - `tb_valid && tb_last` pushes the pair and moves to DRAIN.
  - Cycles with `tb_valid` low hold state (traceback stall).
- **Push at full** (`sp == ALIGN_DEPTH`): the pair is dropped and `error` is set. If `tb_last` is set, the block still moves to DRAIN.
- **Entry to DRAIN:** `align_len` is loaded with the final `sp`, including the last push.
- **DRAIN:**
  - `out_valid` = 1.
  - Output symbols = `stack[sp-1]`.
  - `out_last` = (`sp == 1`).
  - `out_valid && out_ready` pops, decrementing `sp`.
  - Popping the last pair returns the block to IDLE.
- **`tb_valid` in DRAIN:** the pair is ignored, `error` is set, and the drain continues undisturbed.
- **Counter width:** `sp` is `LEN_W` wide. It never wraps: no underflow (pop only when `out_valid`) and no overflow (saturates at `ALIGN_DEPTH`).
- **Output data:** the symbol outputs are combinational reads of registered state only.
- **Outside DRAIN:** `out_valid` = 0, `out_last` = 0, and the symbol outputs are 0.

## Timing
- **Reset values:** state IDLE, `sp` = 0, `out_valid` = 0, `out_last` = 0, both symbol outputs 0, `align_len` = 0, `busy` = 0, `error` = 0. Stack contents are not reset.
- **Push:** a pair sampled on edge N is stored at edge N.
- **Latency:** the first `out_valid` is asserted in the cycle after the edge that accepts `tb_last`.
- **Drain throughput:** one pair per cycle while `out_ready` is high.
- **Stall:** while `out_ready` is low, `out_valid` and all output data stay stable.
- **Total time** for an N-pair alignment with `out_ready` held high: N collect cycles + N drain cycles. A new collection may begin in the cycle after the final pop.
- **`align_len`:** holds its value from DRAIN entry until the first push of the next collection. It is not cleared at that push; it is only overwritten at the next DRAIN entry.
- **Reset mid-operation:** asserting `rst_n` low at any time forces every reset value immediately. The partial alignment is discarded.

## Structure
- **`design_variables` package:** add `ALIGN_DEPTH`, `ALIGN_LEN_W`, `GAP_BIT` (= `LETTER_WIDTH`), and the typedef `align_pair_t` (packed `{query_sym, database_sym}`).
- **`alignment_writer` module:** holds the FSM enum locally.
- **Sub-module `align_lifo`:** a register stack with push, pop, `sp`, full and empty. The FSM wraps it.

## Test plan
- **Eight-pair forward order:** push pairs P0..P7, with P7 carrying `tb_last`, `out_ready` = 1. Expect outputs P7..P0 over 8 consecutive cycles, `out_last` only on P0, `align_len` = 8.
- **Gap symbols:** push `{3'b100, 3'b011}` then `{3'b010, 3'b100}` with `tb_last`. Expect `{010, 100}` first, then `{100, 011}`.
- **Backpressure:** toggle `out_ready` 1,0,0,1 during DRAIN. Expect output data to hold during the 0 cycles and no pair lost or duplicated.
- **Full:** push 65 pairs, the last with `tb_last`. Expect `error` = 1, `align_len` = 64, and the 65th pair absent from the output.
- **Protocol error:** assert `tb_valid` during DRAIN. Expect `error` = 1 and an unchanged output sequence. The next IDLE push clears `error`.
- **Reset mid-collect:** after 3 pushes, pulse `rst_n` low. Expect every output at its reset value. A new 1-pair `tb_last` collection then drains exactly that single pair, with `align_len` = 1.
